instr_fetch_unit: RTL and testbench

- Sequential instruction-fetch front end; the producing end of the control decoder's interface.
- Fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction, and its zero-extended 8-bit opcode, to decode/execute over a valid/ready handshake.
- Takes the resolved jump/branch_eq/branch_not_eq/alu_zero signals back and computes the next PC.

---
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 tb/tb_instr_fetch_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Sequential instruction-fetch front end: fetches one instruction at a time over
// a req/ack memory handshake, issues it over valid/ready, then resolves the next PC.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [7:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              jump,
    input  logic              branch_eq,
    input  logic              branch_not_eq,
    input  logic              alu_zero,
    input  logic              halt,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(32'h0FFF_FFFF);

    state_t            state;
    state_t            state_next;
    logic              issue_fire;
    logic              branch_taken;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ack)    state_next = ISSUE;
            ISSUE:   if (instr_ready) state_next = halt ? HALTED : FETCH;
            HALTED:  if (!halt)       state_next = FETCH;
            default:                  state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == ISSUE);
    end

    assign issue_fire = (state == ISSUE) && instr_ready;
    assign imem_addr  = pc;
    assign pc_plus4   = pc + ADDR_W'(4);
    assign opcode     = {2'b00, instr[31:26]};

    // Jump keeps the region bits of pc+4, not of pc, so a jump sitting in the last
    // word of a 256 MB region lands in the following region.
    always_comb begin
        jump_target   = (pc_plus4 & ~LOW_MASK) | ADDR_W'({instr[25:0], 2'b00});
        branch_offset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
        branch_taken  = (branch_eq & alu_zero) | (branch_not_eq & ~alu_zero);
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            fetch_count <= '0;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                instr <= imem_rdata;
            end
            if (issue_fire) begin
                pc          <= next_pc;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: next-PC vector table, hand-written handshake
// sequences, and a randomized run against an instruction-level reference model.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        branch_eq;
    logic        branch_not_eq;
    logic        alu_zero;
    logic        halt;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RST_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .jump         (jump),
        .branch_eq    (branch_eq),
        .branch_not_eq(branch_not_eq),
        .alu_zero     (alu_zero),
        .halt         (halt),
        .fetch_count  (fetch_count)
    );

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic        j;
        logic        beq;
        logic        bne;
        logic        z;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        instr_ready   = 1'b0;
        jump          = 1'b0;
        branch_eq     = 1'b0;
        branch_not_eq = 1'b0;
        alu_zero      = 1'b0;
        halt          = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic serveFetch(input logic [31:0] word, input int delay);
        int n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            checkOutput("fetch_timeout", 32'(imem_req), 32'd1);
            return;
        end
        repeat (delay) tick();
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic acceptInstr(input logic j, input logic be, input logic bn,
                               input logic z, input logic h, input int delay);
        int n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!instr_valid) begin
            checkOutput("issue_timeout", 32'(instr_valid), 32'd1);
            return;
        end
        repeat (delay) tick();
        jump          = j;
        branch_eq     = be;
        branch_not_eq = bn;
        alu_zero      = z;
        halt          = h;
        instr_ready   = 1'b1;
        tick();
        clearInputs();
    endtask

    // Reaches an arbitrary start PC from reset: a jump covers region 0, and a
    // +0xFFFC branch from just below 0x10000000 carries into region 1.
    task automatic gotoPc(input logic [31:0] target);
        logic [31:0] mid;
        mid = target - 32'h0001_0000;
        doReset();
        if (target[31:28] == 4'h0) begin
            serveFetch({6'h02, target[27:2]}, 0);
            acceptInstr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end else begin
            serveFetch({6'h02, mid[27:2]}, 0);
            acceptInstr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            serveFetch({6'h04, 10'h0, 16'h3FFF}, 0);
            acceptInstr(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        end
        checkOutput("goto_pc", imem_addr, target);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        gotoPc(v.start_pc);
        serveFetch(v.word, 0);
        checkOutput($sformatf("vec%0d_held_pc", idx), pc, v.start_pc);
        acceptInstr(v.j, v.beq, v.bne, v.z, 1'b0, 0);
        checkOutput($sformatf("vec%0d_req", idx), 32'(imem_req), 32'd1);
        checkOutput($sformatf("vec%0d_next_pc", idx), imem_addr, v.exp_pc);
    endtask

    function automatic logic [31:0] refNext(input logic [31:0] cur_pc, input logic [31:0] word,
                                            input logic j, input logic be, input logic bn,
                                            input logic z);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        off = $signed(word[15:0]);
        if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if ((be && z) || (bn && !z)) return seq + 32'(off * 4);
        return seq;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addrs[$];
        int          req_cycles;
        int          valid_cycles;
        int          m_phase;
        logic [31:0] m_pc;
        logic [31:0] m_cnt;
        logic [31:0] m_instr;
        logic        do_rst;

        vecs.push_back('{32'h0000_0200, 32'hC400_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0214});
        vecs.push_back('{32'h0000_0200, 32'hC400_0004, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204});
        vecs.push_back('{32'h0000_0200, 32'hC400_0004, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0204});
        vecs.push_back('{32'h0000_0200, 32'hC400_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0214});
        vecs.push_back('{32'h0000_0200, 32'hC400_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_01FC});
        vecs.push_back('{32'h1000_0010, 32'hC000_0040, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0100});
        vecs.push_back('{32'h0000_0200, 32'hC400_0004, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0214});
        vecs.push_back('{32'h0000_0200, 32'hC400_0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204});
        vecs.push_back('{32'h0FFF_FFFC, 32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0040});
        vecs.push_back('{32'h0FFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000});
        vecs.push_back('{32'h0000_0004, 32'h1000_FFF0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFC8});

        // Reset state and back-to-back best-case throughput
        doReset();
        checkOutput("rst_req", 32'(imem_req), 32'd1);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_addr", imem_addr, RST_PC);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_opcode", 32'(opcode), 32'h0);
        checkOutput("rst_count", fetch_count, 32'h0);
        checkOutput("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        for (int c = 0; c < 6; c++) begin
            if (imem_req) addrs.push_back(imem_addr);
            if (c == 1) begin
                checkOutput("t1_valid", 32'(instr_valid), 32'd1);
                checkOutput("t1_opcode", 32'(opcode), 32'h2D);
            end
            imem_ack    = imem_req;
            imem_rdata  = 32'hB400_0000;
            instr_ready = instr_valid;
            tick();
        end
        clearInputs();
        checkOutput("t1_nreq", addrs.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("t1_addr%0d", k),
                        (addrs.size() > k) ? addrs[k] : 32'hDEAD_BEEF,
                        RST_PC + 32'(4 * k));
        end
        checkOutput("t1_count", fetch_count, 32'd3);

        // Slow memory and slow downstream: request and instruction held stable
        doReset();
        req_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (imem_req) req_cycles++;
            checkOutput("t2_addr_stable", imem_addr, RST_PC);
            imem_ack   = (c == 3);
            imem_rdata = 32'h1234_5678;
            tick();
        end
        imem_ack = 1'b0;
        checkOutput("t2_req_cycles", req_cycles, 32'd4);
        checkOutput("t2_req_dropped", 32'(imem_req), 32'd0);
        valid_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            if (instr_valid) valid_cycles++;
            checkOutput("t2_instr_stable", instr, 32'h1234_5678);
            checkOutput("t2_pc_stable", pc, RST_PC);
            instr_ready = (c == 2);
            tick();
        end
        instr_ready = 1'b0;
        checkOutput("t2_valid_cycles", valid_cycles, 32'd3);
        checkOutput("t2_valid_dropped", 32'(instr_valid), 32'd0);
        checkOutput("t2_count", fetch_count, 32'd1);

        // Next-PC table
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // halt raised while a fetch is still pending
        doReset();
        halt = 1'b1;
        tick();
        checkOutput("t5_fetch_continues", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1000_0003;
        tick();
        imem_ack = 1'b0;
        checkOutput("t5_issued", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        branch_eq   = 1'b1;
        alu_zero    = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch_eq   = 1'b0;
        alu_zero    = 1'b0;
        checkOutput("t5_halt_req", 32'(imem_req), 32'd0);
        checkOutput("t5_halt_valid", 32'(instr_valid), 32'd0);
        checkOutput("t5_halt_pc", pc, 32'h0000_0110);
        tick();
        tick();
        checkOutput("t5_still_halted", 32'(imem_req), 32'd0);
        halt = 1'b0;
        tick();
        checkOutput("t5_resume_req", 32'(imem_req), 32'd1);
        checkOutput("t5_resume_addr", imem_addr, 32'h0000_0110);
        checkOutput("t5_count", fetch_count, 32'd1);

        // Reset while an instruction is being issued
        doReset();
        for (int k = 0; k < 5; k++) begin
            serveFetch(32'h0000_0000, 0);
            acceptInstr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        serveFetch(32'hB400_0000, 0);
        checkOutput("t6_pre_count", fetch_count, 32'd5);
        checkOutput("t6_pre_valid", 32'(instr_valid), 32'd1);
        reset       = 1'b1;
        instr_ready = 1'b1;
        tick();
        checkOutput("t6_valid", 32'(instr_valid), 32'd0);
        checkOutput("t6_req", 32'(imem_req), 32'd1);
        checkOutput("t6_addr", imem_addr, RST_PC);
        checkOutput("t6_count", fetch_count, 32'd0);
        checkOutput("t6_opcode", 32'(opcode), 32'd0);
        reset = 1'b0;
        clearInputs();

        // Randomized traffic against an instruction-level reference model
        doReset();
        m_phase = 0;
        m_pc    = RST_PC;
        m_cnt   = 32'd0;
        m_instr = 32'd0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            checkOutput("rnd_req", 32'(imem_req), 32'(m_phase == 0));
            checkOutput("rnd_valid", 32'(instr_valid), 32'(m_phase == 1));
            checkOutput("rnd_pc", pc, m_pc);
            checkOutput("rnd_count", fetch_count, m_cnt);
            if (m_phase == 1) begin
                checkOutput("rnd_instr", instr, m_instr);
                checkOutput("rnd_opcode", 32'(opcode), m_instr >> 26);
            end
            do_rst        = ($urandom_range(0, 299) == 0);
            imem_ack      = imem_req && ($urandom_range(0, 2) == 0);
            imem_rdata    = $urandom;
            instr_ready   = ($urandom_range(0, 2) == 0);
            halt          = ($urandom_range(0, 4) == 0);
            jump          = ($urandom_range(0, 3) == 0);
            branch_eq     = 1'($urandom_range(0, 1));
            branch_not_eq = 1'($urandom_range(0, 1));
            alu_zero      = 1'($urandom_range(0, 1));
            reset         = do_rst;
            if (do_rst) begin
                m_phase = 0;
                m_pc    = RST_PC;
                m_cnt   = 32'd0;
                m_instr = 32'd0;
            end else if (m_phase == 0) begin
                if (imem_ack) begin
                    m_instr = imem_rdata;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (instr_ready) begin
                    m_pc    = refNext(m_pc, m_instr, jump, branch_eq, branch_not_eq, alu_zero);
                    m_cnt   = m_cnt + 32'd1;
                    m_phase = halt ? 2 : 0;
                end
            end else begin
                if (!halt) m_phase = 0;
            end
            tick();
        end
        reset = 1'b0;
        clearInputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
